floo_axi_test_responder: RTL and testbench



---
 rtl/floo_axi_test_responder.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_floo_axi_test_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_axi_test_responder.sv
// AXI4 test subordinate: reads return an address pattern, writes are checked against it.
// Define FLOO_AXI_TEST_RSP_STATS_EN to build the read/write/error transaction counters.
package floo_axi_test_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [0:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;
endpackage

module floo_axi_test_responder #(
  parameter int unsigned          AddrWidth   = 48,
  parameter int unsigned          DataWidth   = 64,
  parameter int unsigned          IdWidth     = 4,
  parameter int unsigned          UserWidth   = 1,
  parameter logic [AddrWidth-1:0] MemBaseAddr = '0,
  parameter logic [AddrWidth-1:0] MemSize     = AddrWidth'('h1_0000),
  parameter int unsigned          RspLatency  = 4,
  parameter type                  axi_req_t   = floo_axi_test_pkg::axi_req_t,
  parameter type                  axi_rsp_t   = floo_axi_test_pkg::axi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  axi_req_t    axi_req_i,
  output axi_rsp_t    axi_rsp_o,
  output logic [31:0] mismatch_cnt_o,
  output logic [31:0] rd_txn_cnt_o,
  output logic [31:0] wr_txn_cnt_o,
  output logic [31:0] err_cnt_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned Lanes     = DataWidth / 32;
  localparam logic [31:0] AlignMask = ~(32'(StrbWidth) - 32'd1);
  localparam logic [7:0]  Lat       = 8'(RspLatency);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] BurstIncr  = 2'b01;

  localparam logic [1:0] RIdle = 2'd0, RWait = 2'd1, RData = 2'd2;
  localparam logic [1:0] WIdle = 2'd0, WData = 2'd1, WWait = 2'd2, WResp = 2'd3;

  function automatic logic [DataWidth-1:0] pattern(input logic [31:0] a);
    logic [31:0] base;
    base = a & AlignMask;
    pattern = '0;
    for (int i = 0; i < int'(Lanes); i++) pattern[32*i +: 32] = base + 32'(4 * i);
  endfunction

  // Burst type errors win over address decode errors; only the start address is decoded.
  function automatic logic [1:0] decode(input logic [AddrWidth-1:0] addr, input logic [1:0] burst);
    logic [AddrWidth:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, MemBaseAddr};
    hi = lo + {1'b0, MemSize};
    if (burst[1])               decode = RespSlvErr;
    else if (a >= lo && a < hi) decode = RespOkay;
    else                        decode = RespDecErr;
  endfunction

  logic [1:0]         r_state_q, r_state_d, w_state_q, w_state_d;
  logic [7:0]         r_cnt_q, r_cnt_d, w_cnt_q, w_cnt_d;
  logic [IdWidth-1:0] r_id_q, r_id_d, w_id_q, w_id_d;
  logic [31:0]        r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic [7:0]         r_len_q, r_len_d, w_len_q, w_len_d;
  logic [7:0]         r_beat_q, r_beat_d, w_beat_q, w_beat_d;
  logic [2:0]         r_size_q, r_size_d, w_size_q, w_size_d;
  logic [1:0]         r_burst_q, r_burst_d, w_burst_q, w_burst_d;
  logic [1:0]         r_resp_q, r_resp_d, w_resp_q, w_resp_d;
  logic [31:0]        mismatch_cnt_q, mismatch_cnt_d, mism_add;
  logic [32:0]        mism_sum;
  logic [DataWidth-1:0] w_pat;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      RIdle: begin
        if (axi_req_i.ar_valid) begin
          r_id_d    = axi_req_i.ar.id;
          r_addr_d  = axi_req_i.ar.addr[31:0] & AlignMask;
          r_len_d   = axi_req_i.ar.len;
          r_size_d  = axi_req_i.ar.size;
          r_burst_d = axi_req_i.ar.burst;
          r_resp_d  = decode(axi_req_i.ar.addr, axi_req_i.ar.burst);
          r_beat_d  = '0;
          r_cnt_d   = Lat;
          r_state_d = (Lat == 8'd0) ? RData : RWait;
        end
      end
      RWait: begin
        r_cnt_d = r_cnt_q - 8'd1;
        if (r_cnt_q == 8'd1) r_state_d = RData;
      end
      RData: begin
        if (axi_req_i.r_ready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            r_beat_d = r_beat_q + 8'd1;
            if (r_burst_q == BurstIncr) r_addr_d = r_addr_q + (32'd1 << r_size_q);
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // A misplaced or missing w_last poisons the response; the burst still ends on w_last.
  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_resp_d  = w_resp_q;
    mism_add  = '0;
    w_pat     = pattern(w_addr_q);
    case (w_state_q)
      WIdle: begin
        if (axi_req_i.aw_valid) begin
          w_id_d    = axi_req_i.aw.id;
          w_addr_d  = axi_req_i.aw.addr[31:0] & AlignMask;
          w_len_d   = axi_req_i.aw.len;
          w_size_d  = axi_req_i.aw.size;
          w_burst_d = axi_req_i.aw.burst;
          w_resp_d  = decode(axi_req_i.aw.addr, axi_req_i.aw.burst);
          w_beat_d  = '0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (axi_req_i.w_valid) begin
          if (w_resp_q == RespOkay) begin
            for (int j = 0; j < int'(StrbWidth); j++) begin
              if (axi_req_i.w.strb[j] && (axi_req_i.w.data[8*j +: 8] != w_pat[8*j +: 8]))
                mism_add = mism_add + 32'd1;
            end
          end
          if (axi_req_i.w.last != (w_beat_q == w_len_q)) w_resp_d = RespSlvErr;
          w_beat_d = w_beat_q + 8'd1;
          if (w_burst_q == BurstIncr) w_addr_d = w_addr_q + (32'd1 << w_size_q);
          if (axi_req_i.w.last) begin
            w_cnt_d   = Lat;
            w_state_d = (Lat == 8'd0) ? WResp : WWait;
          end
        end
      end
      WWait: begin
        w_cnt_d = w_cnt_q - 8'd1;
        if (w_cnt_q == 8'd1) w_state_d = WResp;
      end
      WResp: begin
        if (axi_req_i.b_ready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    mism_sum       = {1'b0, mismatch_cnt_q} + {1'b0, mism_add};
    mismatch_cnt_d = mism_sum[32] ? 32'hFFFF_FFFF : mism_sum[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= RIdle;  w_state_q <= WIdle;
      r_cnt_q   <= '0;     w_cnt_q   <= '0;
      r_id_q    <= '0;     w_id_q    <= '0;
      r_addr_q  <= '0;     w_addr_q  <= '0;
      r_len_q   <= '0;     w_len_q   <= '0;
      r_beat_q  <= '0;     w_beat_q  <= '0;
      r_size_q  <= '0;     w_size_q  <= '0;
      r_burst_q <= '0;     w_burst_q <= '0;
      r_resp_q  <= '0;     w_resp_q  <= '0;
      mismatch_cnt_q <= '0;
    end else begin
      r_state_q <= r_state_d;  w_state_q <= w_state_d;
      r_cnt_q   <= r_cnt_d;    w_cnt_q   <= w_cnt_d;
      r_id_q    <= r_id_d;     w_id_q    <= w_id_d;
      r_addr_q  <= r_addr_d;   w_addr_q  <= w_addr_d;
      r_len_q   <= r_len_d;    w_len_q   <= w_len_d;
      r_beat_q  <= r_beat_d;   w_beat_q  <= w_beat_d;
      r_size_q  <= r_size_d;   w_size_q  <= w_size_d;
      r_burst_q <= r_burst_d;  w_burst_q <= w_burst_d;
      r_resp_q  <= r_resp_d;   w_resp_q  <= w_resp_d;
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = (w_state_q == WIdle);
    axi_rsp_o.ar_ready = (r_state_q == RIdle);
    axi_rsp_o.w_ready  = (w_state_q == WData);
    axi_rsp_o.b_valid  = (w_state_q == WResp);
    axi_rsp_o.b.id     = w_id_q;
    axi_rsp_o.b.resp   = w_resp_q;
    axi_rsp_o.b.user   = UserWidth'(0);
    axi_rsp_o.r_valid  = (r_state_q == RData);
    axi_rsp_o.r.id     = r_id_q;
    axi_rsp_o.r.data   = pattern(r_addr_q);
    axi_rsp_o.r.resp   = r_resp_q;
    axi_rsp_o.r.last   = (r_beat_q == r_len_q);
    axi_rsp_o.r.user   = UserWidth'(0);
  end

  assign mismatch_cnt_o = mismatch_cnt_q;

`ifdef FLOO_AXI_TEST_RSP_STATS_EN
  logic        rd_done, wr_done;
  logic [31:0] rd_txn_cnt_q, rd_txn_cnt_d, wr_txn_cnt_q, wr_txn_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    rd_done      = (r_state_q == RData) && axi_req_i.r_ready && (r_beat_q == r_len_q);
    wr_done      = (w_state_q == WResp) && axi_req_i.b_ready;
    rd_txn_cnt_d = rd_txn_cnt_q + 32'(rd_done);
    wr_txn_cnt_d = wr_txn_cnt_q + 32'(wr_done);
    err_cnt_d    = err_cnt_q + 32'(rd_done && (r_resp_q != RespOkay))
                             + 32'(wr_done && (w_resp_q != RespOkay));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_txn_cnt_q <= '0;
      wr_txn_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      rd_txn_cnt_q <= rd_txn_cnt_d;
      wr_txn_cnt_q <= wr_txn_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rd_txn_cnt_o = rd_txn_cnt_q;
  assign wr_txn_cnt_o = wr_txn_cnt_q;
  assign err_cnt_o    = err_cnt_q;
`else
  assign rd_txn_cnt_o = '0;
  assign wr_txn_cnt_o = '0;
  assign err_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_floo_axi_test_responder.sv
// Bench for floo_axi_test_responder: directed and random AXI traffic against a transaction-level model.
module tb_floo_axi_test_responder;
  import floo_axi_test_pkg::*;

  localparam logic [47:0] Base = 48'h0000_0010_0000;
  localparam logic [47:0] Size = 48'h0000_0001_0000;
  localparam int          Lat  = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  axi_req_t    req;
  axi_rsp_t    rsp;
  logic [31:0] mism, rdc, wrc, errc;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  int          mism_exp = 0, rd_exp = 0, wr_exp = 0, err_exp = 0;
  logic [63:0] wxor [256];
  logic [7:0]  wstrb [256];

  floo_axi_test_responder #(
    .MemBaseAddr(Base),
    .MemSize(Size),
    .RspLatency(Lat)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .axi_req_i(req),
    .axi_rsp_o(rsp),
    .mismatch_cnt_o(mism),
    .rd_txn_cnt_o(rdc),
    .wr_txn_cnt_o(wrc),
    .err_cnt_o(errc)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every 32-bit lane of a bus word at aligned address A carries A + 4*lane.
  function automatic logic [63:0] pat_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {b + 32'd4, b};
  endfunction

  function automatic logic [31:0] beat_addr(input logic [47:0] addr, input int n,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    a = {addr[31:3], 3'b000};
    if (burst == 2'b01) a = a + (32'(n) << size);
    return {a[31:3], 3'b000};
  endfunction

  function automatic logic [1:0] exp_resp(input logic [47:0] a, input logic [1:0] burst);
    if (burst >= 2'd2) return 2'b10;
    if (a >= Base && (a - Base) < Size) return 2'b00;
    return 2'b11;
  endfunction

  function automatic int bytes_diff(input logic [63:0] x, input logic [7:0] strb);
    int c;
    c = 0;
    for (int j = 0; j < 8; j++) if (strb[j] && x[8*j +: 8] != 8'h00) c++;
    return c;
  endfunction

  function automatic logic [47:0] rand_addr();
    int s;
    s = $urandom_range(9);
    if (s == 0) return Base + Size + 48'($urandom_range(255));
    if (s == 1) return Base - 48'($urandom_range(256, 1));
    return Base + 48'($urandom_range(32'hFFFF));
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_mismatch_cnt"}, 64'(mism), 64'(mism_exp));
`ifdef FLOO_AXI_TEST_RSP_STATS_EN
    checkOutput({tag, "_rd_txn_cnt"}, 64'(rdc), 64'(rd_exp));
    checkOutput({tag, "_wr_txn_cnt"}, 64'(wrc), 64'(wr_exp));
    checkOutput({tag, "_err_cnt"}, 64'(errc), 64'(err_exp));
`else
    checkOutput({tag, "_stats_tied"}, {rdc, wrc | errc}, 64'd0);
`endif
  endtask

  // Runs an optional read and an optional write concurrently; wxor/wstrb hold per-beat write corruption.
  task automatic applyStimulus(input logic do_rd, input logic [3:0] rid, input logic [47:0] raddr,
                               input logic [7:0] rlen, input logic [2:0] rsize, input logic [1:0] rburst,
                               input logic do_wr, input logic [3:0] wid, input logic [47:0] waddr,
                               input logic [7:0] wlen, input logic [2:0] wsize, input logic [1:0] wburst,
                               input int wlast_at, input int pct, input string tag);
    int rs, ws, rbeat, wbeat, budget, mexp;
    int unsigned ar_cyc, aw_cyc, wl_cyc;
    logic rfirst, bfirst, rstall, ar_hs, aw_hs, w_hs, r_hs, b_hs, rhold_last;
    logic [63:0] rhold_data;
    logic [1:0] rresp, wresp;
    rs = do_rd ? 0 : 3;
    ws = do_wr ? 0 : 4;
    rresp = exp_resp(raddr, rburst);
    wresp = exp_resp(waddr, wburst);
    if (wlast_at != int'(wlen)) wresp = 2'b10;
    mexp = 0;
    if (wresp == 2'b00) for (int b = 0; b <= int'(wlen); b++) mexp += bytes_diff(wxor[b], wstrb[b]);
    rfirst = 1'b1; bfirst = 1'b1; rstall = 1'b0; rbeat = 0; wbeat = 0; budget = 3000;
    ar_cyc = 0; aw_cyc = 0; wl_cyc = 0; rhold_data = '0; rhold_last = 1'b0;
    while ((rs != 3 || ws != 4) && budget > 0) begin
      ar_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0; r_hs = 1'b0; b_hs = 1'b0;
      if (rs == 0) begin
        req.ar_valid = 1'b1;
        req.ar = '{id: rid, addr: raddr, len: rlen, size: rsize, burst: rburst};
        if (rsp.ar_ready) begin ar_hs = 1'b1; ar_cyc = cyc; end
      end else if (rs == 1) begin
        req.r_ready = ($urandom_range(99) < pct);
        if (rsp.r_valid) begin
          if (rfirst) begin
            checkOutput({tag, "_r_first_latency"}, 64'(cyc - ar_cyc), 64'(1 + Lat));
            rfirst = 1'b0;
          end
          if (rstall) begin
            checkOutput({tag, "_r_stable_data"}, rsp.r.data, rhold_data);
            checkOutput({tag, "_r_stable_last"}, 64'(rsp.r.last), 64'(rhold_last));
          end
          if (req.r_ready) begin
            checkOutput({tag, "_r_id_resp_last"}, {rsp.r.id, rsp.r.resp, rsp.r.last},
                        {rid, rresp, rbeat == int'(rlen)});
            if (rburst < 2'd2)
              checkOutput({tag, "_r_data"}, rsp.r.data, pat_of(beat_addr(raddr, rbeat, rsize, rburst)));
            r_hs = 1'b1;
          end else begin
            rstall = 1'b1;
            rhold_data = rsp.r.data;
            rhold_last = rsp.r.last;
          end
        end
      end
      if (ws <= 1) begin
        req.w_valid = 1'b1;
        req.w.data = pat_of(beat_addr(waddr, wbeat, wsize, wburst)) ^ wxor[wbeat];
        req.w.strb = wstrb[wbeat];
        req.w.last = (wbeat == wlast_at);
      end
      if (ws == 0) begin
        req.aw_valid = 1'b1;
        req.aw = '{id: wid, addr: waddr, len: wlen, size: wsize, burst: wburst};
        checkOutput({tag, "_w_stall_before_aw"}, 64'(rsp.w_ready), 64'd0);
        if (rsp.aw_ready) begin aw_hs = 1'b1; aw_cyc = cyc; end
      end else if (ws == 1) begin
        if (rsp.w_ready) begin
          w_hs = 1'b1;
          if (wbeat == wlast_at) wl_cyc = cyc;
        end
      end else if (ws == 2) begin
        req.b_ready = ($urandom_range(99) < pct);
        if (rsp.b_valid) begin
          if (bfirst) begin
            checkOutput({tag, "_b_first_latency"}, 64'(cyc - wl_cyc), 64'(1 + Lat));
            bfirst = 1'b0;
          end
          if (req.b_ready) begin
            checkOutput({tag, "_b_id_resp"}, {rsp.b.id, rsp.b.resp}, {wid, wresp});
            b_hs = 1'b1;
          end
        end
      end
      tick();
      if (ar_hs) begin req.ar_valid = 1'b0; rs = 1; end
      if (r_hs) begin
        rstall = 1'b0;
        if (rbeat == int'(rlen)) begin rs = 3; req.r_ready = 1'b0; end
        rbeat++;
      end
      if (aw_hs) begin req.aw_valid = 1'b0; ws = 1; end
      if (w_hs) begin
        if (wbeat == wlast_at) begin ws = 2; req.w_valid = 1'b0; end
        wbeat++;
      end
      if (b_hs) begin ws = 4; req.b_ready = 1'b0; end
      budget--;
    end
    checkOutput({tag, "_completed"}, {62'd0, rs == 3, ws == 4}, 64'd3);
    if (do_rd && do_wr) checkOutput({tag, "_accepted_together"}, 64'(aw_cyc), 64'(ar_cyc));
    req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
    req.r_ready = 1'b0; req.b_ready = 1'b0;
    if (do_rd) begin rd_exp++; if (rresp != 2'b00) err_exp++; end
    if (do_wr) begin wr_exp++; if (wresp != 2'b00) err_exp++; mism_exp += mexp; end
    checkCounters(tag);
  endtask

  task automatic clearWrite();
    for (int b = 0; b < 256; b++) begin wxor[b] = '0; wstrb[b] = 8'hFF; end
  endtask

  initial begin
    int budget;
    logic seen;
    req = '0;
    clearWrite();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_ready", {61'd0, rsp.aw_ready, rsp.ar_ready, rsp.w_ready}, 64'b110);
    checkOutput("reset_valids", {62'd0, rsp.r_valid, rsp.b_valid}, 64'd0);
    checkCounters("reset");
    rst_ni = 1'b1;
    tick();

    $display("[TB] directed read, latency and pattern");
    applyStimulus(1, 4'd2, Base + 48'h100, 8'd3, 3'd3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 100, "rd_basic");

    $display("[TB] directed writes");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, Base, 8'd1, 3'd3, 2'b01, 1, 100, "wr_good");
    wxor[0] = 64'h0000_0000_00A5_0000;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd6, Base, 8'd1, 3'd3, 2'b01, 1, 100, "wr_corrupt");
    checkOutput("wr_corrupt_one_byte", 64'(mism), 64'd1);
    wstrb[0] = 8'hFB;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, Base, 8'd1, 3'd3, 2'b01, 1, 100, "wr_masked");
    checkOutput("wr_masked_unchanged", 64'(mism), 64'd1);
    clearWrite();

    $display("[TB] error responses");
    applyStimulus(1, 4'd3, Base + Size, 8'd3, 3'd3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 100, "rd_decerr");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd9, Base + 48'h40, 8'd1, 3'd3, 2'b10, 1, 100, "wr_wrap");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd1, Base + 48'h80, 8'd3, 3'd3, 2'b01, 1, 100, "wr_early_last");

    $display("[TB] concurrent read and write with back-pressure");
    applyStimulus(1, 4'd4, Base + 48'h200, 8'd5, 3'd3, 2'b01,
                  1, 4'd8, Base + 48'h300, 8'd3, 3'd2, 2'b01, 3, 50, "concurrent");

    $display("[TB] random traffic");
    for (int it = 0; it < 40; it++) begin
      logic dr, dw;
      logic [1:0] rb, wb;
      logic [7:0] rl, wl;
      dr = $urandom_range(1);
      dw = dr ? 1'($urandom_range(1)) : 1'b1;
      rb = ($urandom_range(9) == 0) ? 2'b10 : 2'($urandom_range(1));
      wb = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(1));
      rl = 8'($urandom_range(7));
      wl = 8'($urandom_range(7));
      for (int b = 0; b < 8; b++) begin
        wstrb[b] = 8'($urandom);
        wxor[b] = ($urandom_range(3) == 0) ? {$urandom, $urandom} : 64'd0;
      end
      applyStimulus(dr, 4'($urandom), rand_addr(), rl, 3'($urandom_range(3)), rb,
                    dw, 4'($urandom), rand_addr(), wl, 3'($urandom_range(3)), wb, int'(wl),
                    $urandom_range(100, 30), "random");
    end
    clearWrite();

    $display("[TB] reset in the middle of a read burst");
    req.ar = '{id: 4'd1, addr: Base + 48'h40, len: 8'd3, size: 3'd3, burst: 2'b01};
    req.ar_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    budget = 50;
    while (!rsp.r_valid && budget > 0) begin tick(); budget--; end
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    checkOutput("rst_beat1_valid", {62'd0, rsp.r_valid, rsp.r.last}, 64'b10);
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_async_rvalid", 64'(rsp.r_valid), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    req.r_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rsp.r_valid) seen = 1'b1;
      tick();
    end
    req.r_ready = 1'b0;
    checkOutput("rst_no_stale_beats", 64'(seen), 64'd0);
    checkOutput("rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
    mism_exp = 0; rd_exp = 0; wr_exp = 0; err_exp = 0;
    checkCounters("after_reset");
    applyStimulus(1, 4'd6, Base + 48'h8, 8'd1, 3'd3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 100, "rd_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
